inv_sub_bytes_seq: RTL
======================

// Module: inv_sub_bytes_seq
// PURPOSE
//  Iterative AES-128 InvSubBytes engine for the decryption datapath. Accepts a full
//  128-bit state over a valid/ready handshake and substitutes every byte through the
//  inverse S-box, LANES bytes per cycle, reusing LANES inv_sbox instances.
//  Sits between InvShiftRows and AddRoundKey in the decrypt round loop.
//  Returns the result over a valid/ready handshake.
// PARAMETERS
//  LANES  4  Bytes substituted per cycle. Legal values: 1, 2, 4, 8 or 16; any other
//            value is an elaboration error. NCYC = 16/LANES.
// PORTS
//  clk        in   1    Clock. All logic is on the rising edge.
//  rst        in   1    Synchronous, active-high reset.
//  in_valid   in   1    in_state is valid.
//  in_ready   out  1    Engine can accept a state (IDLE only).
//  in_state   in   128  Input state. Byte k = in_state[8k+7:8k].
//  out_valid  out  1    out_state holds a completed result.
//  out_ready  in   1    Downstream accepts out_state.
//  out_state  out  128  Result. Byte k = InvSbox(input byte k).
//  busy       out  1    High in SUB and DONE.
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, out_valid=0, busy=0, out_state=128'h0.
//    in_ready=0 while rst=1.
//  - IDLE: in_ready=1. Accept on in_valid&&in_ready: load the work register with
//    in_state, set cnt=0, go to SUB.
//  - SUB: each cycle, bytes [cnt*LANES .. cnt*LANES+LANES-1] of the work register are
//    replaced by their inv_sbox outputs, then cnt increments. On cnt==NCYC-1 go to DONE.
//    in_ready=0. Input changes after acceptance are ignored.
//  - DONE: out_valid=1. out_state = work register, held stable while out_ready=0.
//    On out_ready: out_valid falls next cycle and the FSM returns to IDLE. in_ready stays 0
//    in DONE, so there is no same-cycle re-accept.
//  - Latency: out_valid rises NCYC cycles after the accept edge.
//    Throughput: one state per NCYC+2 cycles with out_ready held at 1.
//  - cnt: width max(1,$clog2(NCYC)), with no wrap. For LANES=16, SUB lasts exactly one cycle.
//  - Reset mid-operation (SUB or DONE): the in-flight state is discarded and all outputs
//    return to their reset values on the next edge.
//  - in_valid while not IDLE: ignored; the upstream must hold in_state until in_ready.
//  - out_state between results: retains the last result; it is only meaningful with
//    out_valid=1.
//  - Illegal FSM encoding: recover to IDLE.
// STRUCTURE
//  - Shared package aes_pkg:
//      AES_BLOCK_W=128 and AES_BYTE_W=8 constants.
//      FSM state typedef {IDLE, SUB, DONE}.
//      256-entry INV_SBOX constant table.
//  - Sub-module inv_sbox:
//      Combinational lookup with ports input_byte[7:0] and output_byte[7:0].
//      LANES instances sit behind a byte-select mux indexed by cnt.
//  - Top: FSM, cnt, 128-bit work register and byte write-back.
// TESTING
//  1. in_state=128'h63636363_63636363_63636363_63636363, out_ready=1 -> out_state=128'h0,
//     with out_valid exactly 4 cycles after accept (LANES=4).
//  2. in_state=128'h76abd7fe2b670130c56f6bf27b777c63 ->
//     out_state=128'h0f0e0d0c0b0a09080706050403020100.
//  3. in_state=128'h0 -> all bytes 0x52. in_state all 0x16 -> all bytes 0xFF.
//     Repeat scenarios 1-3 for LANES=1, 2, 8 and 16 and check latencies of 16, 8, 2 and 1.
//  4. Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_state are stable and
//     in_ready=0. Toggling in_valid/in_state during this time has no effect.
//  5. Assert rst for 1 cycle at cnt==2 mid-SUB -> out_valid=0, busy=0 next cycle, then
//     in_ready=1. A new state is then processed correctly with no residue.
//  6. Back-to-back: in_valid held 1 with out_ready=1 -> accepts are spaced NCYC+2 cycles
//     apart and every result matches a software InvSubBytes model (random 1000 states).

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and the inverse S-box table for the
// decryption datapath.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned AES_BYTE_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } state_t;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box lookup for one byte.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] input_byte,
  output logic [7:0] output_byte
);

  always_comb begin
    output_byte = INV_SBOX[input_byte];
  end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES-128 InvSubBytes engine: substitutes LANES bytes of the work
// register per cycle through shared inv_sbox lanes, with valid/ready on both sides.
module inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_state,
  output logic                   busy
);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam int unsigned LN       = LANES;
  localparam int unsigned NCYC     = 16 / LN;
  localparam int unsigned CNT_W    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

  state_t                 state;
  state_t                 state_nx;
  logic [CNT_W-1:0]       cnt;
  logic [AES_BLOCK_W-1:0] work;
  logic [AES_BLOCK_W-1:0] work_sub;
  logic                   accept;
  int unsigned            base;
  logic [7:0]             lane_in  [LN];
  logic [7:0]             lane_out [LN];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic; unused encodings fall back to IDLE
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = accept ? SUB : IDLE;
      SUB:     state_nx = (cnt == CNT_LAST) ? DONE : SUB;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready = !rst;
      SUB:     busy = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign out_state = work;

  always_comb begin
    base = 32'(cnt) * LN;
  end

  // Lane select and write-back are split so the sbox path is not a false comb loop
  always_comb begin
    for (int unsigned l = 0; l < LN; l++) begin
      lane_in[l] = work[AES_BYTE_W*(base+l) +: AES_BYTE_W];
    end
  end

  always_comb begin
    work_sub = work;
    for (int unsigned l = 0; l < LN; l++) begin
      work_sub[AES_BYTE_W*(base+l) +: AES_BYTE_W] = lane_out[l];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox u_inv_sbox (
      .input_byte  (lane_in[g]),
      .output_byte (lane_out[g])
    );
  end

  // Work register and byte counter; cnt saturates at the last slice
  always_ff @(posedge clk) begin
    if (rst) begin
      work <= '0;
      cnt  <= '0;
    end else if (accept) begin
      work <= in_state;
      cnt  <= '0;
    end else if (state == SUB) begin
      work <= work_sub;
      if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
    end
  end

endmodule
